// File: rtl/aes_pkg.sv
// Shared constants, state encoding and word helpers for the AES-256 key schedule.
package aes_pkg;

   localparam int NUM_ROUND_KEYS = 15;
   localparam int RK_IDX_W       = 4;
   localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NUM_ROUND_KEYS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // GF(2^8) multiply by x, reduced by the AES polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward byte S-box as a flat lookup table.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   // Entry 0 sits in the most significant byte, so byte a lives at bit (255-a)*8.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] bit_lo;

   assign bit_lo = {~a_i, 3'b000};
   assign s_o    = SBOX_TABLE[bit_lo +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the byte S-box to each of the four bytes of a word.
module aes_sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (word_i[8*g +: 8]),
         .s_o (word_o[8*g +: 8])
      );
   end

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: streams the 15 round keys over a valid/ready port,
// keeping the last 8 schedule words in a sliding window.
module aes256_key_expand
   import aes_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [255:0]        key_in,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk_data,
   output logic [RK_IDX_W-1:0] rk_idx,
   output logic                done
);

   state_t              state_q, state_d;
   logic [255:0]        window_q, window_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [127:0]        rk_data_q, rk_data_d;
   logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
   logic                rk_valid_q, rk_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic        n_even;
   logic [31:0] prev_w, sub_in, sub_out, t_w;
   logic [31:0] n0, n1, n2, n3;
   logic [127:0] new4;

   // Next word index n = idx+1 is even exactly when idx is odd.
   assign n_even = rk_idx_q[0];
   assign prev_w = window_q[31:0];
   assign sub_in = n_even ? rot_word(prev_w) : prev_w;

   aes_sub_word u_sub_word (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   assign t_w  = sub_out ^ (n_even ? {rcon_q, 24'h000000} : 32'h0);
   assign n0   = window_q[255:224] ^ t_w;
   assign n1   = window_q[223:192] ^ n0;
   assign n2   = window_q[191:160] ^ n1;
   assign n3   = window_q[159:128] ^ n2;
   assign new4 = {n0, n1, n2, n3};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         window_q   <= '0;
         rcon_q     <= '0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         window_q   <= window_d;
         rcon_q     <= rcon_d;
         rk_data_q  <= rk_data_d;
         rk_idx_q   <= rk_idx_d;
         rk_valid_q <= rk_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      window_d   = window_q;
      rcon_d     = rcon_q;
      rk_data_d  = rk_data_q;
      rk_idx_d   = rk_idx_q;
      rk_valid_d = rk_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            // A start landing in the done cycle is dropped along with starts while busy.
            if (start && !done_q) begin
               window_d   = key_in;
               rk_data_d  = key_in[255:128];
               rk_idx_d   = '0;
               rcon_d     = 8'h01;
               rk_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (rk_idx_q == '0) begin
                  rk_data_d = window_q[127:0];
                  rk_idx_d  = RK_IDX_W'(1);
               end else if (rk_idx_q == LAST_IDX) begin
                  rk_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end else begin
                  rk_data_d = new4;
                  window_d  = {window_q[127:0], new4};
                  rk_idx_d  = rk_idx_q + RK_IDX_W'(1);
                  if (n_even) begin
                     rcon_d = xtime(rcon_q);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_data  = rk_data_q;
   assign rk_idx   = rk_idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Scoreboard bench for aes256_key_expand: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every handshake.
module tb_aes256_key_expand;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] data;
      bit           chk_data;
   } exp_t;

   localparam logic [255:0] KEY_A =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_Z = 256'h0;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [255:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         done;

   int   checks   = 0;
   int   fails    = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   bit           stall_q = 1'b0;
   logic [127:0] prev_data;
   logic [3:0]   prev_idx;

   aes256_key_expand dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_idx   (rk_idx),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input logic [255:0] key, input logic [127:0] k2,
                           input logic [127:0] k3, input logic [127:0] k14, input bit chk14);
      exp_t e;
      for (int i = 0; i < 15; i++) begin
         e.idx      = 4'(i);
         e.chk_data = (i <= 3) || (i == 14 && chk14);
         case (i)
            0:       e.data = key[255:128];
            1:       e.data = key[127:0];
            2:       e.data = k2;
            3:       e.data = k3;
            14:      e.data = k14;
            default: e.data = '0;
         endcase
         sb.push_back(e);
      end
   endtask

   task automatic push_a();
      push_run(KEY_A, 128'h9ba354118e6925afa51a8b5f2067fcde,
               128'ha8b09c1a93d194cdbe49846eb75d5b9a,
               128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
   endtask

   task automatic push_z();
      push_run(KEY_Z, 128'h62636363626363636263636362636363,
               128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, 128'h0, 1'b0);
   endtask

   task automatic start_pulse(input logic [255:0] key, input string name);
      key_in = key;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk({name, "_lat_valid"}, 128'(rk_valid), 128'd1);
      chk({name, "_lat_idx"}, 128'(rk_idx), 128'd0);
   endtask

   task automatic wait_done(input int budget, input string name, output int n);
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, 128'(done), 128'd1);
   endtask

   task automatic wait_idx(input logic [3:0] target, input int budget, input string name);
      int n = 0;
      while (rk_idx != target && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_reach_idx"}, 128'(rk_idx), 128'(target));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_data_stable", rk_data, prev_data);
            chk("stall_idx_stable", 128'(rk_idx), 128'(prev_idx));
         end
         if (rk_valid && rk_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_key_idx", 128'(rk_idx), 128'hffff);
            end else begin
               e = sb.pop_front();
               chk("rk_idx", 128'(rk_idx), 128'(e.idx));
               if (e.chk_data) chk($sformatf("rk_data_idx%0d", e.idx), rk_data, e.data);
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_all_keys_seen", 128'(sb.size()), 128'd0);
            chk("done_busy_low", 128'(busy), 128'd0);
         end
         stall_q   = rk_valid && !rk_ready;
         prev_data = rk_data;
         prev_idx  = rk_idx;
      end
   end

   initial begin
      int n;
      int base;
      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
      repeat (3) tick();
      chk("reset_valid", 128'(rk_valid), 128'd0);
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_done", 128'(done), 128'd0);
      chk("reset_idx", 128'(rk_idx), 128'd0);
      chk("reset_data", rk_data, 128'd0);
      rst_n = 1'b1;
      tick();

      // Ready held high: 15 consecutive keys, done 15 cycles after key 0.
      base = done_cnt;
      push_a();
      rk_ready = 1'b1;
      start_pulse(KEY_A, "full");
      chk("full_busy", 128'(busy), 128'd1);
      wait_done(40, "full", n);
      chk("full_cycles_to_done", 128'(n), 128'd15);
      repeat (3) tick();
      chk("full_done_once", 128'(done_cnt - base), 128'd1);

      // Random backpressure.
      base = done_cnt;
      push_a();
      start_pulse(KEY_A, "rnd");
      n = 0;
      while (!done && n < 600) begin
         rk_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("rnd_done_seen", 128'(done), 128'd1);
      rk_ready = 1'b1;
      tick();
      chk("rnd_done_once", 128'(done_cnt - base), 128'd1);

      // Starts during a stall and in the done cycle are ignored.
      push_a();
      start_pulse(KEY_A, "ign");
      wait_idx(4'd5, 40, "ign");
      rk_ready = 1'b0;
      tick();
      key_in = KEY_Z;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      chk("ign_stall_idx", 128'(rk_idx), 128'd5);
      rk_ready = 1'b1;
      wait_done(40, "ign", n);
      key_in = KEY_Z;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("ign_done_start_valid", 128'(rk_valid), 128'd0);
      chk("ign_done_start_busy", 128'(busy), 128'd0);
      push_a();
      start_pulse(KEY_A, "after_done");
      wait_done(40, "after_done", n);
      tick();

      // Reset in the middle of a run.
      base = done_cnt;
      push_a();
      start_pulse(KEY_A, "rst");
      wait_idx(4'd7, 40, "rst");
      rk_ready = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      chk("rst_valid", 128'(rk_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_idx", 128'(rk_idx), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      sb.delete();
      repeat (3) tick();
      chk("rst_no_done", 128'(done_cnt - base), 128'd0);

      // All-zero key, then a different key back to back.
      push_z();
      rk_ready = 1'b1;
      start_pulse(KEY_Z, "zero");
      wait_done(40, "zero", n);
      tick();
      push_a();
      start_pulse(KEY_A, "b2b");
      wait_done(40, "b2b", n);
      tick();
      chk("all_keys_consumed", 128'(sb.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
